// File: rtl/bitmap_header_stripper.sv
// Strips a fixed-length BMP header from an AXI-Stream packet and re-aligns the
// remaining pixel bytes so payload byte 0 lands in tdata[7:0].
module bitmap_header_stripper #(
    parameter int TDATA_WIDTH  = 256,
    parameter int TUSER_WIDTH  = 128,
    parameter int HEADER_BYTES = 54
) (
    input  logic                     axis_aclk,
    input  logic                     axis_reset,
    input  logic [TDATA_WIDTH-1:0]   axis_bitmap_tdata,
    input  logic [TDATA_WIDTH/8-1:0] axis_bitmap_tkeep,
    input  logic [TUSER_WIDTH-1:0]   axis_bitmap_tuser,
    input  logic                     axis_bitmap_tvalid,
    output logic                     axis_bitmap_tready,
    input  logic                     axis_bitmap_tlast,
    output logic [TDATA_WIDTH-1:0]   axis_image_tdata,
    output logic [TDATA_WIDTH/8-1:0] axis_image_tkeep,
    output logic [TUSER_WIDTH-1:0]   axis_image_tuser,
    output logic                     axis_image_tvalid,
    input  logic                     axis_image_tready,
    output logic                     axis_image_tlast,
    output logic                     runt_packet
);

    localparam int W   = TDATA_WIDTH / 8;
    localparam int D   = HEADER_BYTES / W;
    localparam int S   = HEADER_BYTES % W;
    localparam int CW  = $clog2(W + 1);
    localparam int BW  = (D > 1) ? $clog2(D) : 1;
    localparam int DL  = (D > 0) ? D - 1 : 0;
    localparam int RSH = 8 * S;
    localparam int JSH = (S == 0) ? 0 : 8 * (W - S);

    localparam logic [CW-1:0] S_C  = CW'(S);
    localparam logic [CW-1:0] WS_C = CW'(W - S);
    localparam logic [BW-1:0] DL_C = BW'(DL);

    typedef enum logic [1:0] {DROP, LOAD, STREAM, FLUSH} state_t;

    // With no whole beats to drop the packet starts directly in LOAD; with an
    // aligned header the first payload beat passes straight through.
    localparam state_t IDLE_ST  = (D == 0) ? LOAD : DROP;
    localparam state_t AFTER_DR = (S == 0) ? STREAM : LOAD;

    function automatic logic [CW-1:0] count_keep(input logic [W-1:0] k);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < W; i++) n = n + CW'(k[i]);
        return n;
    endfunction

    function automatic logic [W-1:0] keep_mask(input logic [CW-1:0] n);
        logic [W-1:0] m;
        for (int i = 0; i < W; i++) m[i] = (CW'(i) < n);
        return m;
    endfunction

    function automatic logic [TDATA_WIDTH-1:0] mask_bytes(input logic [TDATA_WIDTH-1:0] d,
                                                          input logic [W-1:0] k);
        logic [TDATA_WIDTH-1:0] r;
        for (int i = 0; i < W; i++) r[8*i +: 8] = k[i] ? d[8*i +: 8] : 8'h00;
        return r;
    endfunction

    function automatic logic [CW-1:0] sat_sub(input logic [CW-1:0] a, input logic [CW-1:0] b);
        return (a > b) ? a - b : '0;
    endfunction

    state_t                 state;
    logic [BW-1:0]          beat_cnt;
    logic                   sop;
    logic [TUSER_WIDTH-1:0] tuser_lat;
    logic [TDATA_WIDTH-1:0] res_data;
    logic [CW-1:0]          res_cnt;

    logic [TDATA_WIDTH-1:0] data_p1;
    logic [W-1:0]           keep_p1;
    logic [TUSER_WIDTH-1:0] user_p1;
    logic                   last_p1;
    logic                   vld_p1;
    logic                   runt_p1;

    logic                   load_ok;
    logic                   in_fire;
    logic [CW-1:0]          in_cnt;
    logic [TDATA_WIDTH-1:0] joined;
    logic [TDATA_WIDTH-1:0] shifted_in;
    logic [W-1:0]           short_keep;

    assign load_ok    = !vld_p1 || axis_image_tready;
    assign in_fire    = axis_bitmap_tvalid && axis_bitmap_tready;
    assign in_cnt     = count_keep(axis_bitmap_tkeep);
    assign shifted_in = axis_bitmap_tdata >> RSH;
    assign joined     = res_data | (axis_bitmap_tdata << JSH);
    assign short_keep = keep_mask(WS_C + in_cnt);

    always_comb begin
        axis_bitmap_tready = 1'b0;
        case (state)
            DROP, LOAD: axis_bitmap_tready = 1'b1;
            STREAM:     axis_bitmap_tready = load_ok;
            default:    axis_bitmap_tready = 1'b0;
        endcase
    end

    // Stage p1: control FSM, residual register and registered output beat
    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            state     <= IDLE_ST;
            beat_cnt  <= '0;
            sop       <= 1'b1;
            tuser_lat <= '0;
            res_data  <= '0;
            res_cnt   <= '0;
            data_p1   <= '0;
            keep_p1   <= '0;
            user_p1   <= '0;
            last_p1   <= 1'b0;
            vld_p1    <= 1'b0;
            runt_p1   <= 1'b0;
        end else begin
            runt_p1 <= 1'b0;
            if (load_ok) vld_p1 <= 1'b0;
            if (in_fire) begin
                sop <= axis_bitmap_tlast;
                if (sop) tuser_lat <= axis_bitmap_tuser;
            end

            case (state)
                DROP: begin
                    if (in_fire) begin
                        if (axis_bitmap_tlast) begin
                            runt_p1  <= 1'b1;
                            beat_cnt <= '0;
                        end else if (beat_cnt == DL_C) begin
                            beat_cnt <= '0;
                            res_cnt  <= '0;
                            state    <= AFTER_DR;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end

                LOAD: begin
                    if (in_fire) begin
                        res_data <= shifted_in;
                        res_cnt  <= sat_sub(in_cnt, S_C);
                        if (!axis_bitmap_tlast) begin
                            state <= STREAM;
                        end else if (in_cnt > S_C) begin
                            state <= FLUSH;
                        end else begin
                            runt_p1 <= 1'b1;
                            state   <= IDLE_ST;
                        end
                    end
                end

                STREAM: begin
                    if (in_fire) begin
                        vld_p1  <= 1'b1;
                        user_p1 <= tuser_lat;
                        if (S == 0) begin
                            data_p1 <= mask_bytes(axis_bitmap_tdata, axis_bitmap_tkeep);
                            keep_p1 <= axis_bitmap_tkeep;
                            last_p1 <= axis_bitmap_tlast;
                            if (axis_bitmap_tlast) state <= IDLE_ST;
                        end else begin
                            res_data <= shifted_in;
                            if (axis_bitmap_tlast && in_cnt <= S_C) begin
                                data_p1 <= mask_bytes(joined, short_keep);
                                keep_p1 <= short_keep;
                                last_p1 <= 1'b1;
                                state   <= IDLE_ST;
                            end else begin
                                data_p1 <= joined;
                                keep_p1 <= '1;
                                last_p1 <= 1'b0;
                                if (axis_bitmap_tlast) begin
                                    res_cnt <= in_cnt - S_C;
                                    state   <= FLUSH;
                                end else begin
                                    res_cnt <= WS_C;
                                end
                            end
                        end
                    end
                end

                default: begin
                    if (load_ok) begin
                        vld_p1  <= 1'b1;
                        data_p1 <= mask_bytes(res_data, keep_mask(res_cnt));
                        keep_p1 <= keep_mask(res_cnt);
                        last_p1 <= 1'b1;
                        user_p1 <= tuser_lat;
                        state   <= IDLE_ST;
                    end
                end
            endcase
        end
    end

    assign axis_image_tdata  = data_p1;
    assign axis_image_tkeep  = keep_p1;
    assign axis_image_tuser  = user_p1;
    assign axis_image_tlast  = last_p1;
    assign axis_image_tvalid = vld_p1;
    assign runt_packet       = runt_p1;

endmodule

// File: tb/tb_bitmap_header_stripper.sv
// Scoreboard bench for bitmap_header_stripper: 32-byte beats, 54-byte header,
// ramp input bytes, expected payload beats queued ahead of each packet.
module tb_bitmap_header_stripper;

    localparam int TDW = 256;
    localparam int TUW = 128;
    localparam int W   = 32;
    localparam int HDR = 54;

    typedef struct {
        logic [TDW-1:0] data;
        logic [W-1:0]   keep;
        logic           last;
        logic [TUW-1:0] user;
    } beat_t;

    logic           axis_aclk = 1'b0;
    logic           axis_reset;
    logic [TDW-1:0] axis_bitmap_tdata;
    logic [W-1:0]   axis_bitmap_tkeep;
    logic [TUW-1:0] axis_bitmap_tuser;
    logic           axis_bitmap_tvalid;
    logic           axis_bitmap_tready;
    logic           axis_bitmap_tlast;
    logic [TDW-1:0] axis_image_tdata;
    logic [W-1:0]   axis_image_tkeep;
    logic [TUW-1:0] axis_image_tuser;
    logic           axis_image_tvalid;
    logic           axis_image_tready;
    logic           axis_image_tlast;
    logic           runt_packet;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    exp_runt = 0;
    int    runt_seen = 0;
    int    rdy_mode = 0;
    bit    mon_en = 1'b1;

    bitmap_header_stripper #(
        .TDATA_WIDTH (TDW),
        .TUSER_WIDTH (TUW),
        .HEADER_BYTES(HDR)
    ) dut (
        .axis_aclk         (axis_aclk),
        .axis_reset        (axis_reset),
        .axis_bitmap_tdata (axis_bitmap_tdata),
        .axis_bitmap_tkeep (axis_bitmap_tkeep),
        .axis_bitmap_tuser (axis_bitmap_tuser),
        .axis_bitmap_tvalid(axis_bitmap_tvalid),
        .axis_bitmap_tready(axis_bitmap_tready),
        .axis_bitmap_tlast (axis_bitmap_tlast),
        .axis_image_tdata  (axis_image_tdata),
        .axis_image_tkeep  (axis_image_tkeep),
        .axis_image_tuser  (axis_image_tuser),
        .axis_image_tvalid (axis_image_tvalid),
        .axis_image_tready (axis_image_tready),
        .axis_image_tlast  (axis_image_tlast),
        .runt_packet       (runt_packet)
    );

    always #5 axis_aclk = ~axis_aclk;

    function automatic logic [TDW-1:0] ramp_beat(input int b);
        logic [TDW-1:0] r;
        for (int i = 0; i < W; i++) r[8*i +: 8] = 8'((b * W + i) % 256);
        return r;
    endfunction

    // Expected output: payload is file bytes HDR..total-1, cut into 32-byte beats.
    task automatic push_expect(input int nb, input logic [W-1:0] lk, input logic [TUW-1:0] u);
        beat_t e;
        int total;
        int plen;
        int len;
        total = W * (nb - 1) + $countones(lk);
        plen  = total - HDR;
        if (plen <= 0) exp_runt++;
        for (int off = 0; off < plen; off += W) begin
            len    = (plen - off >= W) ? W : plen - off;
            e.data = '0;
            e.keep = '0;
            for (int i = 0; i < len; i++) begin
                e.data[8*i +: 8] = 8'((HDR + off + i) % 256);
                e.keep[i] = 1'b1;
            end
            e.last = (off + W >= plen);
            e.user = u;
            exp_q.push_back(e);
        end
    endtask

    task automatic send_beat(input logic [TDW-1:0] d, input logic [W-1:0] k,
                             input logic l, input logic [TUW-1:0] u);
        int t;
        t = 0;
        axis_bitmap_tdata  = d;
        axis_bitmap_tkeep  = k;
        axis_bitmap_tlast  = l;
        axis_bitmap_tuser  = u;
        axis_bitmap_tvalid = 1'b1;
        do begin
            @(negedge axis_aclk);
            t++;
        end while (!axis_bitmap_tready && t < 2000);
        checks++;
        if (!axis_bitmap_tready) begin
            errors++;
            $display("FAIL input_handshake tready=%b after %0d cycles, want 1", axis_bitmap_tready, t);
        end
        @(posedge axis_aclk);
        #1;
    endtask

    task automatic send_pkt(input int nb, input logic [W-1:0] lk, input logic [TUW-1:0] u);
        push_expect(nb, lk, u);
        for (int b = 0; b < nb; b++)
            send_beat(ramp_beat(b), (b == nb - 1) ? lk : '1, b == nb - 1, (b == 0) ? u : ~u);
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        axis_bitmap_tvalid = 1'b0;
        axis_bitmap_tlast  = 1'b0;
        rdy_mode = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(negedge axis_aclk);
            t++;
        end
        repeat (5) @(negedge axis_aclk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain pending=%0d want 0", tag, exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (runt_seen != exp_runt) begin
            errors++;
            $display("FAIL %s_runt count=%0d want %0d", tag, runt_seen, exp_runt);
            runt_seen = exp_runt;
        end
        @(posedge axis_aclk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        checks += 6;
        if (axis_image_tvalid !== 1'b0) begin errors++; $display("FAIL %s_tvalid got %b want 0", tag, axis_image_tvalid); end
        if (axis_image_tlast !== 1'b0)  begin errors++; $display("FAIL %s_tlast got %b want 0", tag, axis_image_tlast); end
        if (axis_image_tkeep !== '0)    begin errors++; $display("FAIL %s_tkeep got %h want 0", tag, axis_image_tkeep); end
        if (axis_image_tdata !== '0)    begin errors++; $display("FAIL %s_tdata got %h want 0", tag, axis_image_tdata); end
        if (axis_image_tuser !== '0)    begin errors++; $display("FAIL %s_tuser got %h want 0", tag, axis_image_tuser); end
        if (runt_packet !== 1'b0)       begin errors++; $display("FAIL %s_runt got %b want 0", tag, runt_packet); end
    endtask

    initial begin
        axis_reset         = 1'b1;
        axis_bitmap_tdata  = '0;
        axis_bitmap_tkeep  = '0;
        axis_bitmap_tuser  = '0;
        axis_bitmap_tvalid = 1'b0;
        axis_bitmap_tlast  = 1'b0;
        axis_image_tready  = 1'b1;

        fork
            forever begin
                @(posedge axis_aclk);
                #1;
                case (rdy_mode)
                    1:       axis_image_tready = 1'($urandom_range(0, 1));
                    2:       axis_image_tready = 1'b0;
                    default: axis_image_tready = 1'b1;
                endcase
            end
            forever begin
                @(negedge axis_aclk);
                if (mon_en && !axis_reset) begin
                    if (runt_packet) runt_seen++;
                    if (axis_image_tvalid) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_beat data=%h keep=%h last=%b", axis_image_tdata,
                                     axis_image_tkeep, axis_image_tlast);
                        end else begin
                            if (axis_image_tdata !== exp_q[0].data || axis_image_tkeep !== exp_q[0].keep ||
                                axis_image_tlast !== exp_q[0].last || axis_image_tuser !== exp_q[0].user) begin
                                errors++;
                                $display("FAIL out_beat got data=%h keep=%h last=%b user=%h want data=%h keep=%h last=%b user=%h",
                                         axis_image_tdata, axis_image_tkeep, axis_image_tlast, axis_image_tuser,
                                         exp_q[0].data, exp_q[0].keep, exp_q[0].last, exp_q[0].user);
                            end
                            if (axis_image_tready) void'(exp_q.pop_front());
                        end
                    end
                end
            end
        join_none

        repeat (3) @(posedge axis_aclk);
        @(negedge axis_aclk);
        check_zero("reset");
        @(posedge axis_aclk);
        #1 axis_reset = 1'b0;

        send_pkt(4, 32'hFFFF_FFFF, 128'h0000_1111_2222_3333_4444_5555_6666_0001);
        drain("full_4beat");

        send_pkt(3, 32'h0000_03FF, 128'h0000_0000_0000_0000_0000_0000_0000_0002);
        drain("short_tail");

        send_pkt(2, 32'h003F_FFFF, 128'h0000_0000_0000_0000_0000_0000_0000_0003);
        send_pkt(1, 32'hFFFF_FFFF, 128'h0000_0000_0000_0000_0000_0000_0000_0004);
        drain("runt");

        send_pkt(2, 32'h3FFF_FFFF, 128'hA5A5_5A5A_DEAD_BEEF_0123_4567_89AB_CDEF);
        drain("load_flush");

        rdy_mode = 1;
        send_pkt(4, 32'hFFFF_FFFF, 128'h0000_0000_0000_0000_0000_0000_0000_0051);
        send_pkt(4, 32'hFFFF_FFFF, 128'h0000_0000_0000_0000_0000_0000_0000_0052);
        send_pkt(4, 32'hFFFF_FFFF, 128'h0000_0000_0000_0000_0000_0000_0000_0053);
        drain("stall_b2b");

        rdy_mode = 2;
        mon_en   = 1'b0;
        send_beat(ramp_beat(0), '1, 1'b0, 128'h77);
        send_beat(ramp_beat(1), '1, 1'b0, 128'h78);
        send_beat(ramp_beat(2), '1, 1'b0, 128'h79);
        axis_bitmap_tdata  = ramp_beat(3);
        axis_bitmap_tkeep  = '1;
        axis_bitmap_tlast  = 1'b1;
        axis_bitmap_tvalid = 1'b1;
        @(negedge axis_aclk);
        #1 axis_reset = 1'b1;
        #1 check_zero("mid_reset");
        @(posedge axis_aclk);
        #1 axis_bitmap_tvalid = 1'b0;
        axis_bitmap_tlast = 1'b0;
        @(posedge axis_aclk);
        #1 axis_reset = 1'b0;
        rdy_mode = 0;
        mon_en   = 1'b1;
        send_pkt(4, 32'hFFFF_FFFF, 128'h0000_1111_2222_3333_4444_5555_6666_0001);
        drain("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
